// File: rtl/misr_pkg.sv
// misr_pkg: shared state encoding, tap positions and the MISR step function
package misr_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SKIP, ST_ACCUM, ST_CHECK, ST_DONE} state_t;
    localparam int MAX_W = 256;
    localparam int TAP_MID = 2;
    localparam int TAP_LO = 0;
    function automatic int tap_hi(input int w);
        return w - 1;
    endfunction
    // Operates on a MAX_W-wide container; only the low w bits are meaningful.
    function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] sig, input logic [MAX_W-1:0] data, input int w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] taps;
        mask = (w >= MAX_W) ? '1 : (MAX_W'(1) << w) - MAX_W'(1);
        taps = (sig >> tap_hi(w)) ^ (sig >> TAP_MID) ^ (sig >> TAP_LO);
        return (((sig << 1) | {{(MAX_W-1){1'b0}}, taps[0]}) & mask) ^ data;
    endfunction
endpackage

// File: rtl/misr_reg.sv
// misr_reg: signature register with synchronous clear and step enable
module misr_reg
    import misr_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [WIDTH-1:0]  sig
);
    logic [WIDTH-1:0] sig_q, sig_d;
    always_comb begin
        sig_d = clr ? '0 : en ? WIDTH'(misr_step(MAX_W'(sig_q), MAX_W'(data), WIDTH)) : sig_q;
    end
    always_ff @(posedge clk) begin
        sig_q <= reset ? '0 : sig_d;
    end
    assign sig = sig_q;
endmodule

// File: rtl/misr_sig_checker.sv
// misr_sig_checker: skips a warm-up window, folds COUNT beats into a MISR and compares
module misr_sig_checker
    import misr_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DATA_W = 8,
    parameter int SKIP = 10,
    parameter int COUNT = 80,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  expected,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [WIDTH-1:0]  signature,
    output logic [CNT_W-1:0]  beats
);
    localparam state_t FIRST = (SKIP == 0) ? ST_ACCUM : ST_SKIP;
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP - 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT - 1);
    if (WIDTH < 3 || WIDTH > MAX_W || DATA_W > WIDTH || DATA_W < 1 || SKIP < 0 || COUNT < 1 ||
        SKIP >= (1 << CNT_W) || COUNT >= (1 << CNT_W)) begin : g_param_check
        $error("misr_sig_checker: illegal parameter combination");
    end
    state_t state_q, state_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic pass_q, pass_d, clr, en, acc;
    logic [WIDTH-1:0] sig;
    misr_reg #(.WIDTH(WIDTH), .DATA_W(DATA_W)) u_misr (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .data(in_data), .sig(sig)
    );
    assign in_ready = (state_q == ST_SKIP) || (state_q == ST_ACCUM);
    assign acc = in_valid && in_ready;
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        pass_d = pass_q;
        clr = 1'b0;
        en = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) begin
                clr = 1'b1;
                beats_d = '0;
                pass_d = 1'b0;
                state_d = FIRST;
            end
            ST_SKIP: if (acc) begin
                beats_d = (beats_q == SKIP_LAST) ? '0 : beats_q + 1'b1;
                state_d = (beats_q == SKIP_LAST) ? ST_ACCUM : ST_SKIP;
            end
            ST_ACCUM: if (acc) begin
                en = 1'b1;
                beats_d = beats_q + 1'b1;
                state_d = (beats_q == COUNT_LAST) ? ST_CHECK : ST_ACCUM;
            end
            ST_CHECK: begin
                pass_d = (sig == expected);
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            beats_q <= '0;
            pass_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            pass_q <= pass_d;
        end
    end
    assign busy = (state_q == ST_SKIP) || (state_q == ST_ACCUM) || (state_q == ST_CHECK);
    assign done = (state_q == ST_DONE);
    assign pass = pass_q;
    assign signature = sig;
    assign beats = beats_q;
endmodule

// File: tb/tb_misr_sig_checker.sv
// tb_misr_sig_checker: directed small-config cases plus a random default-config run against a queue model
module tb_misr_sig_checker;
    localparam int D_SKIP = 10;
    localparam int D_COUNT = 80;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    logic s_reset = 1'b1, s_start = 1'b0, s_in_valid = 1'b0;
    logic [7:0] s_expected = '0;
    logic [3:0] s_in_data = '0;
    logic s_in_ready, s_busy, s_done, s_pass;
    logic [7:0] s_signature;
    logic [3:0] s_beats;
    logic d_reset = 1'b1, d_start = 1'b0, d_in_valid = 1'b0;
    logic [63:0] d_expected = '0;
    logic [7:0] d_in_data = '0;
    logic d_in_ready, d_busy, d_done, d_pass;
    logic [63:0] d_signature;
    logic [15:0] d_beats;
    misr_sig_checker #(.WIDTH(8), .DATA_W(4), .SKIP(2), .COUNT(3), .CNT_W(4)) u_small (
        .clk(clk), .reset(s_reset), .start(s_start), .expected(s_expected),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready), .busy(s_busy),
        .done(s_done), .pass(s_pass), .signature(s_signature), .beats(s_beats)
    );
    misr_sig_checker u_dflt (
        .clk(clk), .reset(d_reset), .start(d_start), .expected(d_expected),
        .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready), .busy(d_busy),
        .done(d_done), .pass(d_pass), .signature(d_signature), .beats(d_beats)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    // Signature of a beat list for a w-bit MISR, straight from the shift/feedback rule.
    function automatic logic [63:0] fold(input logic [63:0] q[$], input int w);
        logic [63:0] s, mask, fb;
        s = '0;
        mask = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
        foreach (q[i]) begin
            fb = ((s >> (w - 1)) ^ (s >> 2) ^ s) & 64'd1;
            s = (((s << 1) | fb) & mask) ^ q[i];
        end
        return s;
    endfunction
    logic [63:0] mq[$];
    int m_mode = 0;
    int m_n = 0;
    logic m_pass = 1'b0;
    bit m_on = 1'b0;
    // Reference for the default instance: phase 0 idle, 1 warm-up, 2 folding, 3 compare, 4 finished.
    initial forever begin
        @(posedge clk);
        if (d_reset) begin
            m_mode = 0;
            m_n = 0;
            m_pass = 1'b0;
            mq.delete();
            m_on = 1'b1;
        end else if (m_on) begin
            case (m_mode)
                0, 4: if (d_start) begin
                    mq.delete();
                    m_n = 0;
                    m_pass = 1'b0;
                    m_mode = (D_SKIP == 0) ? 2 : 1;
                end
                1: if (d_in_valid) begin
                    m_n++;
                    if (m_n == D_SKIP) begin
                        m_n = 0;
                        m_mode = 2;
                    end
                end
                2: if (d_in_valid) begin
                    mq.push_back(64'(d_in_data));
                    m_n++;
                    if (m_n == D_COUNT) m_mode = 3;
                end
                default: begin
                    m_pass = (fold(mq, 64) == d_expected);
                    m_mode = 4;
                end
            endcase
        end
        #1;
        if (m_on) begin
            chk("d_in_ready", d_in_ready, m_mode == 1 || m_mode == 2);
            chk("d_busy", d_busy, m_mode >= 1 && m_mode <= 3);
            chk("d_done", d_done, m_mode == 4);
            chk("d_signature", d_signature, fold(mq, 64));
            chk("d_beats", d_beats, 64'(m_n));
            if (m_mode == 4) chk("d_pass", d_pass, m_pass);
        end
    end
    task automatic s_pulse_start();
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
    endtask
    task automatic s_beat(input logic [3:0] d, input int bub);
        repeat (bub) begin
            @(negedge clk);
            s_in_valid = 1'b0;
            s_in_data = 4'($urandom);
            #1 chk("s_in_ready_bubble", s_in_ready, 1);
        end
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_data = d;
        #1 chk("s_in_ready", s_in_ready, 1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask
    task automatic s_feed(input int bmax, input bit start_mid, input int n);
        logic [3:0] st [5];
        st = '{4'hF, 4'hF, 4'h1, 4'h2, 4'h4};
        for (int i = 0; i < n; i++) begin
            s_beat(st[i], $urandom_range(bmax, 0));
            if (start_mid && i == 3) begin
                s_pulse_start();
                chk("s_busy_start_ignored", s_busy, 1);
                chk("s_beats_start_ignored", s_beats, 2);
            end
        end
    endtask
    task automatic s_finish(input bit exp_pass);
        chk("s_sig_in_check", s_signature, 8'h07);
        chk("s_done_in_check", s_done, 0);
        chk("s_busy_in_check", s_busy, 1);
        @(posedge clk);
        #1;
        chk("s_done", s_done, 1);
        chk("s_busy_done", s_busy, 0);
        chk("s_pass", s_pass, exp_pass);
        chk("s_sig_done", s_signature, 8'h07);
        chk("s_beats_done", s_beats, 3);
    endtask
    task automatic s_chk_idle(input string tag);
        chk({tag, "_in_ready"}, s_in_ready, 0);
        chk({tag, "_busy"}, s_busy, 0);
        chk({tag, "_done"}, s_done, 0);
        chk({tag, "_pass"}, s_pass, 0);
        chk({tag, "_sig"}, s_signature, 0);
        chk({tag, "_beats"}, s_beats, 0);
    endtask
    task automatic d_run(input bit flip, input int reset_at);
        logic [7:0] st [90];
        logic [63:0] q[$];
        int k;
        for (int i = 0; i < 90; i++) st[i] = 8'($urandom);
        for (int i = D_SKIP; i < 90; i++) q.push_back(64'(st[i]));
        d_expected = fold(q, 64);
        if (flip) begin
            k = $urandom_range(89, D_SKIP);
            st[k] = st[k] ^ 8'(1 << $urandom_range(7, 0));
        end
        @(negedge clk);
        d_start = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        for (int i = 0; i < 90; i++) begin
            if (i == reset_at) begin
                @(negedge clk);
                d_reset = 1'b1;
                @(posedge clk);
                #1;
                d_reset = 1'b0;
                chk("d_idle_after_reset", d_busy, 0);
                return;
            end
            repeat ($urandom_range(2, 0)) begin
                @(negedge clk);
                d_in_valid = 1'b0;
                d_in_data = 8'($urandom);
                d_start = ($urandom_range(5, 0) == 0);
            end
            @(negedge clk);
            d_start = 1'b0;
            d_in_valid = 1'b1;
            d_in_data = st[i];
            @(posedge clk);
            #1;
            d_in_valid = 1'b0;
        end
        d_in_valid = 1'b1;
        d_in_data = 8'($urandom);
        k = 0;
        while (!d_done && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        d_in_valid = 1'b0;
        chk("d_done_timeout", d_done, 1);
        chk("d_pass_result", d_pass, !flip);
        chk("d_beats_at_done", d_beats, D_COUNT);
        if (!flip) chk("d_sig_equals_expected", d_signature, d_expected);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        logic [63:0] pq[$];
        pq.push_back(64'h1);
        pq.push_back(64'h2);
        chk("model_pin_12", fold(pq, 8), 64'h01);
        pq.push_back(64'h4);
        chk("model_pin_124", fold(pq, 8), 64'h07);
        pq.delete();
        pq.push_back(64'h80);
        pq.push_back(64'h0);
        chk("model_pin_wrap", fold(pq, 8), 64'h01);
        repeat (2) @(posedge clk);
        #1;
        s_chk_idle("s_reset");
        s_reset = 1'b0;
        d_reset = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_data = 4'h5;
        repeat (2) @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        s_chk_idle("s_idle_valid");
        s_expected = 8'h07;
        s_pulse_start();
        chk("s_busy_after_start", s_busy, 1);
        s_feed(0, 1'b0, 5);
        s_finish(1'b1);
        s_pulse_start();
        s_feed(3, 1'b0, 5);
        s_finish(1'b1);
        s_expected = 8'h06;
        s_pulse_start();
        s_feed(0, 1'b0, 5);
        s_finish(1'b0);
        s_expected = 8'h07;
        s_pulse_start();
        s_feed(0, 1'b0, 4);
        @(negedge clk);
        s_reset = 1'b1;
        @(posedge clk);
        #1;
        s_reset = 1'b0;
        s_chk_idle("s_mid_reset");
        s_pulse_start();
        s_feed(0, 1'b0, 5);
        s_finish(1'b1);
        s_pulse_start();
        s_feed(1, 1'b1, 5);
        s_finish(1'b1);
        s_pulse_start();
        chk("s_restart_done", s_done, 0);
        chk("s_restart_pass", s_pass, 0);
        chk("s_restart_sig", s_signature, 0);
        chk("s_restart_beats", s_beats, 0);
        chk("s_restart_busy", s_busy, 1);
        s_feed(0, 1'b0, 5);
        s_finish(1'b1);
        d_run(1'b0, -1);
        d_run(1'b1, -1);
        d_run(1'b0, 50);
        d_run(1'b0, -1);
        d_run(1'b1, -1);
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
